// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the memory request arbiter.
//   HEAD_W/ADDR_W/DATA_W - payload field widths
//   SRC_*                - source encodings driven on mem_src_out
//   arb_state_e          - arbiter FSM states
package mem_arb_pkg;

  localparam int unsigned HEAD_W = 16;
  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 128;

  localparam logic [1:0] SRC_D_REP  = 2'd0;
  localparam logic [1:0] SRC_D_REQ  = 2'd1;
  localparam logic [1:0] SRC_I_REP  = 2'd2;
  localparam logic [1:0] SRC_INFIFO = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } arb_state_e;

endpackage

// File: rtl/mem_arb_rr_pick.sv
// mem_arb_rr_pick: combinational round-robin picker over four requesters.
// The search starts one past the previous winner and wraps 3->0.
//   req_i        [3:0] request vector, bit index = source encoding
//   last_grant_i [1:0] previous winner
//   winner_o     [1:0] selected source (0 when nothing requests)
//   any_valid_o        at least one request present
module mem_arb_rr_pick (
  input  logic [3:0] req_i,
  input  logic [1:0] last_grant_i,
  output logic [1:0] winner_o,
  output logic       any_valid_o
);

  logic [1:0] idx;

  always_comb begin
    winner_o    = '0;
    any_valid_o = 1'b0;
    idx         = '0;
    for (int unsigned i = 1; i <= 4; i++) begin
      // 2-bit addition wraps naturally, giving the mod-4 search order.
      idx = last_grant_i + 2'(i);
      if (!any_valid_o && req_i[idx]) begin
        winner_o    = idx;
        any_valid_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_req_arbiter.sv
// mem_req_arbiter: grants one of four memory requesters (D-cache reply,
// D-cache request, I-cache reply, inbound fifos) per memory transaction.
// IDLE picks a winner round-robin and latches its payload, ISSUE strobes
// v_mem_out and the winner's ack for one cycle, WAIT holds until the
// memory fsm pulses mem_access_done.
// Optional feature macro: MEM_ARB_TIMEOUT_EN enables a WAIT watchdog that
// sets sticky timeout_err and returns to IDLE after TIMEOUT_CYCLES.
// Ports:
//   clk, rst (async, active-low)
//   v_d_rep/v_d_req/v_i_rep/v_INfifos           requester valids
//   local_d_*/local_i_addr_in/infifos_*         requester payloads
//   mem_access_done                             completion pulse
//   ack_d_rep/ack_d_req/ack_i_rep/ack_INfifos   one-cycle accept pulses
//   v_mem_out, mem_src_out, mem_head/addr/data_out  issued transaction
//   arb_busy, timeout_err                       status
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter int unsigned CNT_W          = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              v_d_rep,
  input  logic              v_d_req,
  input  logic              v_i_rep,
  input  logic              v_INfifos,
  input  logic [HEAD_W-1:0] local_d_head_in,
  input  logic [HEAD_W-1:0] infifos_head_in,
  input  logic [ADDR_W-1:0] local_d_addr_in,
  input  logic [ADDR_W-1:0] local_i_addr_in,
  input  logic [ADDR_W-1:0] infifos_addr_in,
  input  logic [DATA_W-1:0] local_d_data_in,
  input  logic [DATA_W-1:0] infifos_data_in,
  input  logic              mem_access_done,
  output logic              ack_d_rep,
  output logic              ack_d_req,
  output logic              ack_i_rep,
  output logic              ack_INfifos,
  output logic              v_mem_out,
  output logic [1:0]        mem_src_out,
  output logic [HEAD_W-1:0] mem_head_out,
  output logic [ADDR_W-1:0] mem_addr_out,
  output logic [DATA_W-1:0] mem_data_out,
  output logic              arb_busy,
  output logic              timeout_err
);

  arb_state_e        state_q, state_d;
  logic [1:0]        last_q, last_d;
  logic [1:0]        src_q, src_d;
  logic [HEAD_W-1:0] head_q, head_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;

  logic [1:0]        win;
  logic              any_v;

  mem_arb_rr_pick u_pick (
    .req_i        ({v_INfifos, v_i_rep, v_d_req, v_d_rep}),
    .last_grant_i (last_q),
    .winner_o     (win),
    .any_valid_o  (any_v)
  );

`ifdef MEM_ARB_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`else
  logic unused_cfg;
  assign unused_cfg = ^{TIMEOUT_CYCLES, CNT_W};
`endif

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    src_d   = src_q;
    head_d  = head_q;
    addr_d  = addr_q;
    data_d  = data_q;
`ifdef MEM_ARB_TIMEOUT_EN
    err_d   = err_q;
    // Held at zero outside WAIT, so it is already clear on WAIT entry.
    cnt_d   = (state_q == ST_WAIT) ? cnt_q + CNT_W'(1) : '0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (any_v) begin
          state_d = ST_ISSUE;
          src_d   = win;
          last_d  = win;
          unique case (win)
            SRC_D_REP, SRC_D_REQ: begin
              head_d = local_d_head_in;
              addr_d = local_d_addr_in;
              data_d = local_d_data_in;
            end
            SRC_I_REP: begin
              // I-cache replies carry only an address.
              head_d = '0;
              addr_d = local_i_addr_in;
              data_d = '0;
            end
            default: begin
              head_d = infifos_head_in;
              addr_d = infifos_addr_in;
              data_d = infifos_data_in;
            end
          endcase
        end
      end
      ST_ISSUE: state_d = ST_WAIT;
      ST_WAIT: begin
        if (mem_access_done) begin
          state_d = ST_IDLE;
        end
`ifdef MEM_ARB_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d = ST_IDLE;
          err_d   = 1'b1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      last_q  <= SRC_INFIFO;
      src_q   <= '0;
      head_q  <= '0;
      addr_q  <= '0;
      data_q  <= '0;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      src_q   <= src_d;
      head_q  <= head_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
`ifdef MEM_ARB_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  always_comb begin
    ack_d_rep   = 1'b0;
    ack_d_req   = 1'b0;
    ack_i_rep   = 1'b0;
    ack_INfifos = 1'b0;
    v_mem_out   = (state_q == ST_ISSUE);
    if (state_q == ST_ISSUE) begin
      unique case (src_q)
        SRC_D_REP: ack_d_rep   = 1'b1;
        SRC_D_REQ: ack_d_req   = 1'b1;
        SRC_I_REP: ack_i_rep   = 1'b1;
        default:   ack_INfifos = 1'b1;
      endcase
    end
  end

  assign arb_busy     = (state_q != ST_IDLE);
  assign mem_src_out  = src_q;
  assign mem_head_out = head_q;
  assign mem_addr_out = addr_q;
  assign mem_data_out = data_q;
`ifdef MEM_ARB_TIMEOUT_EN
  assign timeout_err  = err_q;
`else
  assign timeout_err  = 1'b0;
`endif

endmodule
